gru_seq_engine: RTL and testbench

//  Sequential, parametrised GRU cell: IN_DIM inputs, HID_DIM hidden units, signed Q(DATA_WIDTH,FRACT_WIDTH).

---
 rtl/gru_pkg.sv | 53 +++++
 rtl/gru_act_lut.sv | 39 +++
 rtl/gru_mac_unit.sv | 33 +++
 rtl/gru_seq_engine.sv | 196 +++++++++++++++++++
 tb/tb_gru_seq_engine.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/gru_pkg.sv
// Shared types and fixed-point helpers for the sequential GRU engine.
// rq() is the one requantiser used everywhere, so every rounding/saturation point behaves identically.
package gru_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE_MAC,
        ST_GATE_ACT,
        ST_CAND_MAC,
        ST_CAND_ACT,
        ST_DONE
    } state_t;

    localparam int GATE_Z = 0;
    localparam int GATE_R = 1;
    localparam int GATE_N = 2;

    function automatic int one_q(input int fw);
        return 1 << fw;
    endfunction

    function automatic int acc_w(input int dw, input int k);
        return 2 * dw + $clog2(k + 1) + 1;
    endfunction

    // Counter width that stays legal for a single-entry range.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Floor shift by fw, then saturate to a signed dw-bit range.
    function automatic logic signed [31:0] rq(input logic signed [63:0] v, input int fw, input int dw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = v >>> fw;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        return 32'(s);
    endfunction

    function automatic logic signed [31:0] mulrq(input logic signed [31:0] a, input logic signed [31:0] b,
                                                 input int fw, input int dw);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return rq(p, fw, dw);
    endfunction

endpackage

// File: rtl/gru_act_lut.sv
// Activation tables: piecewise-linear sigmoid and tanh on signed Q-format addresses.
// sigmoid(a) = clamp(a/4 + 0.5, 0, 1); tanh(a) = clamp(a, -1, 1).
module sigmoid_lut #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int FW = 5
) (
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    int v;
    always_comb begin
        v = (int'($signed(addr)) >>> 2) + (1 << (FW - 1));
        if (v < 0)
            v = 0;
        else if (v > (1 << FW))
            v = 1 << FW;
        data = DW'(v);
    end
endmodule

module tanh_lut #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int FW = 5
) (
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    int v;
    always_comb begin
        v = int'($signed(addr));
        if (v > (1 << FW))
            v = 1 << FW;
        else if (v < -(1 << FW))
            v = -(1 << FW);
        data = DW'(v);
    end
endmodule

// File: rtl/gru_mac_unit.sv
// Signed multiply-accumulate with clear-on-load; exposes the requantised accumulator.
module gru_mac_unit
    import gru_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 5,
    parameter int ACC_W       = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         clr,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] q
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        acc;

    assign prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);

    // clr loads the first product instead of adding, so column 0 starts a fresh sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en)
            acc <= clr ? ACC_W'(prod) : acc + ACC_W'(prod);
    end

    assign q = DATA_WIDTH'(rq(64'(acc), FRACT_WIDTH, DATA_WIDTH));

endmodule

// File: rtl/gru_seq_engine.sv
// Time-multiplexed GRU cell: z/r gates on two MACs, candidate on one, then h update.
// h is held across steps and only replaced when the whole new vector is ready.
module gru_seq_engine
    import gru_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int FRACT_WIDTH = 5,
    parameter  int IN_DIM      = 4,
    parameter  int HID_DIM     = 4,
    parameter  int AW          = 8,
    parameter  int DW          = 8,
    localparam int K           = IN_DIM + HID_DIM,
    localparam int NW          = 3 * HID_DIM * (K + 1),
    localparam int ADDR_W      = $clog2(NW)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wt_we,
    input  logic [ADDR_W-1:0]                wt_addr,
    input  logic [DATA_WIDTH-1:0]            wt_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             seq_start,
    input  logic [IN_DIM*DATA_WIDTH-1:0]     x_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [HID_DIM*DATA_WIDTH-1:0]    h_out,
    output logic                             busy
);

    localparam int ACC_W = acc_w(DATA_WIDTH, K);
    localparam int JW    = cw(HID_DIM);
    localparam int KW    = cw(K + 1);
    localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(one_q(FRACT_WIDTH));

    state_t                       state;
    logic [JW-1:0]                j;
    logic [KW-1:0]                k;
    logic signed [DATA_WIDTH-1:0] wram  [NW];
    logic signed [DATA_WIDTH-1:0] xr    [IN_DIM];
    logic signed [DATA_WIDTH-1:0] h     [HID_DIM];
    logic signed [DATA_WIDTH-1:0] hnw   [HID_DIM];
    logic signed [DATA_WIDTH-1:0] z     [HID_DIM];
    logic signed [DATA_WIDTH-1:0] rh    [HID_DIM];
    logic signed [DATA_WIDTH-1:0] hnext [HID_DIM];

    logic                         gate_ph;
    logic [ADDR_W-1:0]            ra0, ra1;
    logic signed [DATA_WIDTH-1:0] opnd, w0, w1, q0, q1;
    logic signed [DATA_WIDTH-1:0] zj, hj, zv, rv, nv, rhv, omz, hnv;
    logic [DW-1:0]                s_z, s_r, t_n;

    assign gate_ph = (state == ST_GATE_MAC);

    // The weight RAM is deliberately not reset; only IDLE writes land.
    always_ff @(posedge clk) begin
        if (wt_we && state == ST_IDLE && int'(wt_addr) < NW)
            wram[wt_addr] <= $signed(wt_data);
    end

    always_comb begin
        ra0 = ADDR_W'(((gate_ph ? GATE_Z : GATE_N) * HID_DIM + int'(j)) * (K + 1) + int'(k));
        ra1 = ADDR_W'((GATE_R * HID_DIM + int'(j)) * (K + 1) + int'(k));
    end

    assign w0 = wram[ra0];
    assign w1 = wram[ra1];

    // Column k operand: x, then h (gates) or r.h (candidate), then ONE for the bias.
    always_comb begin
        opnd = ONE;
        for (int i = 0; i < IN_DIM; i++)
            if (int'(k) == i) opnd = xr[i];
        for (int i = 0; i < HID_DIM; i++)
            if (int'(k) == IN_DIM + i) opnd = gate_ph ? h[i] : rh[i];
    end

    gru_mac_unit #(.DATA_WIDTH(DATA_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .ACC_W(ACC_W)) u_mac0 (
        .clk(clk), .rst_n(rst_n), .en(gate_ph || state == ST_CAND_MAC), .clr(k == '0),
        .a(w0), .b(opnd), .q(q0)
    );

    gru_mac_unit #(.DATA_WIDTH(DATA_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .ACC_W(ACC_W)) u_mac1 (
        .clk(clk), .rst_n(rst_n), .en(gate_ph), .clr(k == '0),
        .a(w1), .b(opnd), .q(q1)
    );

    sigmoid_lut #(.AW(AW), .DW(DW), .FW(FRACT_WIDTH)) u_sig_z (.addr(AW'(q0)), .data(s_z));
    sigmoid_lut #(.AW(AW), .DW(DW), .FW(FRACT_WIDTH)) u_sig_r (.addr(AW'(q1)), .data(s_r));
    tanh_lut    #(.AW(AW), .DW(DW), .FW(FRACT_WIDTH)) u_tanh_n (.addr(AW'(q0)), .data(t_n));

    assign zv = DATA_WIDTH'($signed(s_z));
    assign rv = DATA_WIDTH'($signed(s_r));
    assign nv = DATA_WIDTH'($signed(t_n));

    always_comb begin
        zj = '0;
        hj = '0;
        for (int i = 0; i < HID_DIM; i++)
            if (int'(j) == i) begin
                zj = z[i];
                hj = h[i];
            end
        rhv = DATA_WIDTH'(mulrq(32'(rv), 32'(hj), FRACT_WIDTH, DATA_WIDTH));
        omz = DATA_WIDTH'(rq(64'(32'(ONE) - 32'(zj)), 0, DATA_WIDTH));
        hnv = DATA_WIDTH'(rq(64'(mulrq(32'(omz), 32'(nv), FRACT_WIDTH, DATA_WIDTH)
                                + mulrq(32'(zj), 32'(hj), FRACT_WIDTH, DATA_WIDTH)), 0, DATA_WIDTH));
        for (int i = 0; i < HID_DIM; i++)
            hnext[i] = (int'(j) == i) ? hnv : hnw[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            j         <= '0;
            k         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            h_out     <= '0;
            for (int i = 0; i < IN_DIM; i++)
                xr[i] <= '0;
            for (int i = 0; i < HID_DIM; i++) begin
                h[i]   <= '0;
                hnw[i] <= '0;
                z[i]   <= '0;
                rh[i]  <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < IN_DIM; i++)
                            xr[i] <= $signed(x_in[i*DATA_WIDTH +: DATA_WIDTH]);
                        if (seq_start)
                            for (int i = 0; i < HID_DIM; i++)
                                h[i] <= '0;
                        j        <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_GATE_MAC;
                    end
                end
                ST_GATE_MAC, ST_CAND_MAC: begin
                    if (int'(k) == K) begin
                        k     <= '0;
                        state <= (state == ST_GATE_MAC) ? ST_GATE_ACT : ST_CAND_ACT;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ST_GATE_ACT: begin
                    for (int i = 0; i < HID_DIM; i++)
                        if (int'(j) == i) begin
                            z[i]  <= zv;
                            rh[i] <= rhv;
                        end
                    if (int'(j) == HID_DIM - 1) begin
                        j     <= '0;
                        state <= ST_CAND_MAC;
                    end else begin
                        j     <= j + JW'(1);
                        state <= ST_GATE_MAC;
                    end
                end
                ST_CAND_ACT: begin
                    for (int i = 0; i < HID_DIM; i++)
                        if (int'(j) == i) hnw[i] <= hnv;
                    // Old h feeds every candidate update, so it is swapped only at the very end.
                    if (int'(j) == HID_DIM - 1) begin
                        for (int i = 0; i < HID_DIM; i++) begin
                            h[i]                           <= hnext[i];
                            h_out[i*DATA_WIDTH +: DATA_WIDTH] <= hnext[i];
                        end
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        j     <= j + JW'(1);
                        state <= ST_CAND_MAC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gru_seq_engine.sv
// Directed bench for gru_seq_engine with IN_DIM=2, HID_DIM=2 (K=4, 30 weight words).
module tb_gru_seq_engine;

    localparam int NONE = 31;
    localparam int LAT  = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wt_we = 1'b0;
    logic [4:0]  wt_addr = '0;
    logic [7:0]  wt_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        seq_start = 1'b0;
    logic [15:0] x_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] h_out;
    logic        busy;

    int nchk = 0;
    int nerr = 0;

    gru_seq_engine #(.DATA_WIDTH(8), .FRACT_WIDTH(5), .IN_DIM(2), .HID_DIM(2), .AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .in_valid(in_valid), .in_ready(in_ready), .seq_start(seq_start), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .h_out(h_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ld, fill;
        int a0, d0, a1, d1, a2, d2;
        int x0, x1, seq;
        int e0, e1;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int hval(input int i);
        return int'($signed(h_out[i*8 +: 8]));
    endfunction

    task automatic wt_write(input int a, input int d);
        wt_we   = 1'b1;
        wt_addr = 5'(a);
        wt_data = 8'(d);
        @(posedge clk); #1;
        wt_we   = 1'b0;
    endtask

    task automatic load_all(input int v);
        for (int a = 0; a < 30; a++) wt_write(a, v);
    endtask

    task automatic start_step(input int x0, input int x1, input int seq);
        int t;
        in_valid  = 1'b1;
        x_in      = {8'(x1), 8'(x0)};
        seq_start = (seq != 0);
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        seq_start = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_step(input int x0, input int x1, input int seq, output int lat,
                            output int h0, output int h1);
        start_step(x0, x1, seq);
        wait_out(lat);
        h0 = hval(0);
        h1 = hval(1);
        ack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat, h0, h1;

        // ld fill | a0 d0 a1 d1 a2 d2 | x0 x1 seq | e0 e1
        vt[0]  = '{1,    0, NONE,  0, NONE,   0, NONE, 0,    0,   0, 1,    0,   0};
        vt[1]  = '{1,    0,   24, 32,   29,  32, NONE, 0,    0,   0, 1,   16,  16};
        vt[2]  = '{0,    0, NONE,  0, NONE,   0, NONE, 0,    0,   0, 0,   24,  24};
        vt[3]  = '{0,    0, NONE,  0, NONE,   0, NONE, 0,    0,   0, 0,   28,  28};
        vt[4]  = '{0,    0, NONE,  0, NONE,   0, NONE, 0,    0,   0, 1,   16,  16};
        vt[5]  = '{1,  127, NONE,  0, NONE,   0, NONE, 0,  127, 127, 0,   16,  16};
        vt[6]  = '{0,    0, NONE,  0, NONE,   0, NONE, 0,  127, 127, 1,    0,   0};
        vt[7]  = '{1, -128, NONE,  0, NONE,   0, NONE, 0,  127, 127, 1,  -32, -32};
        vt[8]  = '{0,    0, NONE,  0, NONE,   0, NONE, 0,  127, 127, 0,  -32, -32};
        vt[9]  = '{1,    0,   24, 32,   29, -32,   20, 32, -16,   0, 1,    8, -16};
        vt[10] = '{0,    0,    4, 64, NONE,   0, NONE, 0,  -16,   0, 0,    8, -24};
        vt[11] = '{0,    0,    4,  0,   22,  32, NONE, 0,  -16,   0, 0,   14, -28};

        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle busy", int'(busy), 0);
        chk("idle h_out", int'(h_out), 0);
        chk("idle in_ready", int'(in_ready), 1);

        for (int r = 0; r < 12; r++) begin
            if (vt[r].ld != 0) load_all(vt[r].fill);
            if (vt[r].a0 != NONE) wt_write(vt[r].a0, vt[r].d0);
            if (vt[r].a1 != NONE) wt_write(vt[r].a1, vt[r].d1);
            if (vt[r].a2 != NONE) wt_write(vt[r].a2, vt[r].d2);
            run_step(vt[r].x0, vt[r].x1, vt[r].seq, lat, h0, h1);
            chk($sformatf("row%0d latency", r), lat, LAT);
            chk($sformatf("row%0d h0", r), h0, vt[r].e0);
            chk($sformatf("row%0d h1", r), h1, vt[r].e1);
        end

        // Backpressure: h_out held while out_ready low, a waiting request stalls then runs.
        load_all(0);
        wt_write(24, 32);
        wt_write(29, 32);
        start_step(0, 0, 1);
        wait_out(lat);
        chk("stall latency", lat, LAT);
        in_valid = 1'b1;
        x_in = '0;
        seq_start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d out_valid", c), int'(out_valid), 1);
            chk($sformatf("stall%0d in_ready", c), int'(in_ready), 0);
            chk($sformatf("stall%0d h_out", c), int'(h_out), 16'h1010);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release out_valid", int'(out_valid), 0);
        chk("release in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stalled req busy", int'(busy), 1);
        wait_out(lat);
        chk("stalled req latency", lat, LAT);
        chk("stalled req h0", hval(0), 24);
        chk("stalled req h1", hval(1), 24);
        ack();

        // Reset during CAND_MAC j=1 discards the step and clears h.
        start_step(0, 0, 0);
        repeat (19) begin
            @(posedge clk); #1;
        end
        chk("pre-reset busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst in_ready", int'(in_ready), 1);
        chk("midrst busy", int'(busy), 0);
        chk("midrst h_out", int'(h_out), 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst out_valid", int'(out_valid), 0);
        chk("post-rst in_ready", int'(in_ready), 1);
        run_step(0, 0, 0, lat, h0, h1);
        chk("post-rst latency", lat, LAT);
        chk("post-rst h0", h0, 16);
        chk("post-rst h1", h1, 16);

        // Weight writes while busy must be dropped.
        start_step(0, 0, 1);
        wt_we = 1'b1; wt_addr = 5'd24; wt_data = 8'd0;
        @(posedge clk); #1;
        wt_addr = 5'd29;
        @(posedge clk); #1;
        wt_we = 1'b0;
        wait_out(lat);
        chk("busy-wr h0", hval(0), 16);
        chk("busy-wr h1", hval(1), 16);
        ack();
        run_step(0, 0, 1, lat, h0, h1);
        chk("busy-wr recheck h0", h0, 16);
        chk("busy-wr recheck h1", h1, 16);

        // Write coinciding with the accepting edge is visible to that step.
        wt_we = 1'b1; wt_addr = 5'd24; wt_data = 8'hE0;
        start_step(0, 0, 1);
        wt_we = 1'b0;
        wait_out(lat);
        chk("same-cycle wr latency", lat, LAT - 0);
        chk("same-cycle wr h0", hval(0), -16);
        chk("same-cycle wr h1", hval(1), 16);
        ack();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
